// File: rtl/stopwatch_input_ctrl.sv
// Input conditioning and run/pause control for the stopwatch digit counter.
// Synchronises raw board inputs, debounces the two buttons and drives clean control strobes.
module stopwatch_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause_raw,
    input  logic       btn_reset_raw,
    input  logic       sw_adj_raw,
    input  logic [2:0] sw_sel_raw,
    input  logic [3:0] sw_val_raw,
    output logic       rst,
    output logic       paused,
    output logic       adj,
    output logic       btn_set_pause,
    output logic [2:0] adj_sel,
    output logic [3:0] adj_val
);

    localparam int unsigned RAW_W = 10;
    localparam int unsigned N_BTN = 2;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_RUNNING = 1'b0,
        ST_PAUSED  = 1'b1
    } state_t;

    // Raw bundle layout: {val[3:0], sel[2:0], adj, reset, pause}
    logic [RAW_W-1:0] raw_vec;
    logic [RAW_W-1:0] sync_q [SYNC_STAGES];
    logic [RAW_W-1:0] sync_vec;

    assign raw_vec  = {sw_val_raw, sw_sel_raw, sw_adj_raw, btn_reset_raw, btn_pause_raw};
    assign sync_vec = sync_q[SYNC_STAGES-1];

    // Synchroniser chain shared by every raw input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_vec;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    logic [CNT_W-1:0] db_cnt [N_BTN];
    logic [N_BTN-1:0] btn_sync;
    logic [N_BTN-1:0] db_lvl;
    logic [N_BTN-1:0] db_lvl_d;
    logic [N_BTN-1:0] press_c;

    assign btn_sync = sync_vec[1:0];
    assign press_c  = db_lvl & ~db_lvl_d;

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < N_BTN; b++) begin
                db_cnt[b] <= '0;
            end
            db_lvl   <= '0;
            db_lvl_d <= '0;
        end else begin
            db_lvl_d <= db_lvl;
            for (int b = 0; b < N_BTN; b++) begin
                if (btn_sync[b] == db_lvl[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == CNT_LAST) begin
                    db_cnt[b] <= '0;
                    db_lvl[b] <= btn_sync[b];
                end else begin
                    db_cnt[b] <= db_cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    logic adj_now_c;
    logic adj_rise_c;
    logic pause_press_c;
    logic reset_press_c;

    assign adj_now_c     = sync_vec[2];
    assign adj_rise_c    = adj_now_c & ~adj;
    assign pause_press_c = press_c[0];
    assign reset_press_c = press_c[1];

    state_t state_q;
    state_t state_nxt;
    logic   rst_c;
    logic   set_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PAUSED;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Reset press dominates; adj entry forces a pause; pause press toggles only outside adjust
    always_comb begin
        state_nxt = state_q;
        if (reset_press_c) begin
            state_nxt = ST_PAUSED;
        end else if (adj_rise_c) begin
            state_nxt = ST_PAUSED;
        end else if (pause_press_c && !adj_now_c) begin
            state_nxt = (state_q == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
        end
    end

    always_comb begin
        rst_c = 1'b0;
        set_c = 1'b0;
        if (reset_press_c) begin
            rst_c = 1'b1;
        end else if (pause_press_c && adj_now_c) begin
            set_c = 1'b1;
        end
    end

    // Registered outputs; paused tracks the state register exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst           <= 1'b0;
            btn_set_pause <= 1'b0;
            paused        <= 1'b1;
            adj           <= 1'b0;
            adj_sel       <= '0;
            adj_val       <= '0;
        end else begin
            rst           <= rst_c;
            btn_set_pause <= set_c;
            paused        <= (state_nxt == ST_PAUSED);
            adj           <= adj_now_c;
            adj_sel       <= sync_vec[5:3];
            adj_val       <= sync_vec[9:6];
        end
    end

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Scoreboard bench for stopwatch_input_ctrl: a sliding-window reference model predicts every
// output change, and a negedge monitor matches each observed change against the queue.
module tb_stopwatch_input_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned S = 2;
    // Output vector: {rst, set, paused, adj, sel[2:0], val[3:0]}
    localparam logic [10:0] RESET_V = 11'h100;

    typedef struct {
        int          cyc;
        logic [10:0] v;
    } evt_t;

    logic       clk;
    logic       rst_n;
    logic       bp, br, sa;
    logic [2:0] ss;
    logic [3:0] sv;
    logic       rst, paused, adj, btn_set_pause;
    logic [2:0] adj_sel;
    logic [3:0] adj_val;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    evt_t sbq[$];

    stopwatch_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_pause_raw(bp),
        .btn_reset_raw(br),
        .sw_adj_raw   (sa),
        .sw_sel_raw   (ss),
        .sw_val_raw   (sv),
        .rst          (rst),
        .paused       (paused),
        .adj          (adj),
        .btn_set_pause(btn_set_pause),
        .adj_sel      (adj_sel),
        .adj_val      (adj_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [9:0]  m_pipe [S];
    bit          h [2][D];
    int          fill [2];
    logic [1:0]  m_lvl, m_rose;
    logic        m_paused, m_rst, m_set, m_adj;
    logic [2:0]  m_sel;
    logic [3:0]  m_val;
    logic [10:0] m_prev, m_vec;

    task automatic model_reset();
        for (int i = 0; i < S; i++) m_pipe[i] = '0;
        for (int b = 0; b < 2; b++) begin
            fill[b] = 0;
            for (int j = 0; j < D; j++) h[b][j] = 1'b0;
        end
        m_lvl = '0; m_rose = '0;
        m_paused = 1'b1; m_rst = 1'b0; m_set = 1'b0; m_adj = 1'b0;
        m_sel = '0; m_val = '0;
        m_prev = RESET_V;
    endtask

    task automatic model_step();
        logic [9:0] s;
        logic       pp, rp, arise, n_rst, n_set, n_p, flip;
        s  = m_pipe[S-1];
        pp = m_rose[0];
        rp = m_rose[1];
        arise = s[2] && !m_adj;
        n_rst = 1'b0; n_set = 1'b0; n_p = m_paused;
        if (rp) begin
            n_rst = 1'b1;
            n_p   = 1'b1;
        end else begin
            if (arise) n_p = 1'b1;
            if (pp) begin
                if (s[2]) n_set = 1'b1;
                else      n_p = !m_paused;
            end
        end
        // Button level accepted once the last D samples all disagree with it
        for (int b = 0; b < 2; b++) begin
            for (int j = D - 1; j > 0; j--) h[b][j] = h[b][j-1];
            h[b][0] = s[b];
            if (fill[b] < D) fill[b]++;
            flip = (fill[b] == D);
            for (int j = 0; j < D; j++) if (h[b][j] == m_lvl[b]) flip = 1'b0;
            m_rose[b] = flip && !m_lvl[b];
            if (flip) m_lvl[b] = !m_lvl[b];
        end
        for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = {sv, ss, sa, br, bp};
        m_adj = s[2]; m_sel = s[5:3]; m_val = s[9:6];
        m_rst = n_rst; m_set = n_set; m_paused = n_p;
        m_vec = {m_rst, m_set, m_paused, m_adj, m_sel, m_val};
        if (m_vec != m_prev) sbq.push_back('{cyc: cyc, v: m_vec});
        m_prev = m_vec;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Monitor: every DUT output change must match the next predicted event, cycle for cycle
    initial begin
        logic [10:0] dv, d_prev;
        evt_t e;
        d_prev = RESET_V;
        forever begin
            @(negedge clk);
            dv = {rst, btn_set_pause, paused, adj, adj_sel, adj_val};
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                total++; bad++;
                $display("FAIL missed_evt cyc=%0d got=none required=%h@%0d", cyc, e.v, e.cyc);
            end
            if (!rst_n) begin
                total++;
                if (dv != RESET_V) begin
                    bad++;
                    $display("FAIL reset_val cyc=%0d got=%h required=%h", cyc, dv, RESET_V);
                end
                d_prev = dv;
            end else if (dv != d_prev) begin
                d_prev = dv;
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_evt cyc=%0d got=%h required=none", cyc, dv);
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc || e.v != dv) begin
                        bad++;
                        $display("FAIL evt cyc=%0d got=%h required=%h@%0d", cyc, dv, e.v, e.cyc);
                    end
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; bp = 1'b0; br = 1'b0; sa = 1'b0; ss = '0; sv = '0;
        hold(3);
        rst_n = 1'b1;
        hold(2);
        // Glitch rejected, then a held press runs; release and press again pauses
        bp = 1'b1; hold(3); bp = 1'b0; hold(2); bp = 1'b1; hold(12);
        bp = 1'b0; hold(8); bp = 1'b1; hold(8); bp = 1'b0; hold(8);
        // Run, then reset and pause pressed on the same edge
        bp = 1'b1; hold(8); bp = 1'b0; hold(8);
        bp = 1'b1; br = 1'b1; hold(10); bp = 1'b0; br = 1'b0; hold(8);
        // Run, enter adjust, load a digit
        bp = 1'b1; hold(8); bp = 1'b0; hold(8);
        sa = 1'b1; hold(5); ss = 3'd3; sv = 4'd7; hold(5);
        bp = 1'b1; hold(8); bp = 1'b0; hold(8);
        // Leave adjust, resume with a pause press
        sa = 1'b0; hold(6); bp = 1'b1; hold(8); bp = 1'b0; hold(8);
        // Async reset in the middle of a debounce
        bp = 1'b1; hold(4); rst_n = 1'b0; hold(1); rst_n = 1'b1; hold(12);
        bp = 1'b0; hold(8);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = 1'b1;
            if ($urandom_range(4) == 0) bp = ~bp;
            if ($urandom_range(6) == 0) br = ~br;
            if ($urandom_range(59) == 0) sa = ~sa;
            if ($urandom_range(7) == 0) ss = 3'($urandom_range(7));
            if ($urandom_range(7) == 0) sv = 4'($urandom_range(15));
            if ($urandom_range(599) == 0) rst_n = 1'b0;
            hold(1);
        end
        rst_n = 1'b1; bp = 1'b0; br = 1'b0; sa = 1'b0;
        hold(30);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending required=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
